// File: rtl/fuente_pc_pkg.sv
// -----------------------------------------------------------------------------
// fuente_pc_pkg
// Shared definitions for the registered next-PC generator:
//   - COND_*  : branch condition codes carried on tipo_cond
//   - FPC_*   : encodings of the fuente_pc output (which source fed the PC)
//   - estado_t: sequencer states (boot cycle, normal run, exception vector)
// -----------------------------------------------------------------------------
package fuente_pc_pkg;

    // Conditional branch codes (tipo_cond); 6 and 7 are reserved, never taken.
    localparam logic [2:0] COND_BEQ  = 3'd0;
    localparam logic [2:0] COND_BNE  = 3'd1;
    localparam logic [2:0] COND_BLEZ = 3'd2;
    localparam logic [2:0] COND_BGTZ = 3'd3;
    localparam logic [2:0] COND_BLTZ = 3'd4;
    localparam logic [2:0] COND_BGEZ = 3'd5;

    // Selected next-PC source.
    localparam logic [1:0] FPC_SEQ    = 2'd0;
    localparam logic [1:0] FPC_SALTO  = 2'd1;
    localparam logic [1:0] FPC_JUMP   = 2'd2;
    localparam logic [1:0] FPC_VECTOR = 2'd3;

    typedef enum logic [1:0] {
        ARRANQUE = 2'd0,
        EJECUTA  = 2'd1,
        VECTOR   = 2'd2
    } estado_t;

endpackage

// File: rtl/eval_cond.sv
// -----------------------------------------------------------------------------
// eval_cond
// Purely combinational branch-condition evaluator.
// Ports:
//   i_tipo_cond  condition code (COND_* in fuente_pc_pkg)
//   i_zero       ALU zero flag
//   i_negativo   ALU sign flag
//   o_cond       1 when the condition holds (before gating with salto_cond)
// -----------------------------------------------------------------------------
module eval_cond
    import fuente_pc_pkg::*;
(
    input  logic [2:0] i_tipo_cond,
    input  logic       i_zero,
    input  logic       i_negativo,
    output logic       o_cond
);

    always_comb begin
        o_cond = 1'b0;
        case (i_tipo_cond)
            COND_BEQ:  o_cond = i_zero;
            COND_BNE:  o_cond = !i_zero;
            COND_BLEZ: o_cond = i_negativo | i_zero;
            COND_BGTZ: o_cond = !i_negativo & !i_zero;
            COND_BLTZ: o_cond = i_negativo;
            COND_BGEZ: o_cond = !i_negativo;
            default:   o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/fuente_pc_seq.sv
// -----------------------------------------------------------------------------
// fuente_pc_seq
// Registered next-PC generator for the MIPS32 core. Owns the PC register,
// resolves branch / jump / register-jump / exception requests by fixed
// priority, issues a one-cycle flush after every redirect and counts taken
// control transfers.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_stall            hold PC, state and counter (exception still wins)
//   i_salto_cond       conditional branch in decode; i_tipo_cond selects test
//   i_zero, i_negativo ALU flags feeding the condition
//   i_salto_incond     J/JAL, target from i_dest_j
//   i_salto_reg        JR/JALR, target from i_reg_dest
//   i_inm_ext          sign-extended branch immediate (word offset)
//   i_excepcion        external exception request
//   o_pc, o_pc_mas4    current PC and PC+4
//   o_fuente_pc        winning source this cycle (FPC_*)
//   o_flush            kill the instruction fetched in the previous cycle
//   o_desalineado      one-cycle pulse after a misaligned JR target
//   o_valido           fetch address valid
//   o_cuenta_saltos    taken branch/jump counter (wraps)
// -----------------------------------------------------------------------------
module fuente_pc_seq
    import fuente_pc_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_salto_cond,
    input  logic [2:0]       i_tipo_cond,
    input  logic             i_zero,
    input  logic             i_negativo,
    input  logic             i_salto_incond,
    input  logic             i_salto_reg,
    input  logic [WIDTH-1:0] i_inm_ext,
    input  logic [25:0]      i_dest_j,
    input  logic [WIDTH-1:0] i_reg_dest,
    input  logic             i_excepcion,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_mas4,
    output logic [1:0]       o_fuente_pc,
    output logic             o_flush,
    output logic             o_desalineado,
    output logic             o_valido,
    output logic [CNT_W-1:0] o_cuenta_saltos
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

    estado_t          r_estado;
    logic [WIDTH-1:0] r_pc;
    logic             r_flush;
    logic             r_desal;
    logic             r_valido;
    logic [CNT_W-1:0] r_cuenta;

    logic             w_cond;
    logic             w_tomado;
    logic             w_desal_req;
    logic             w_retenido;
    logic [WIDTH-1:0] w_pc_mas4;
    logic [WIDTH-1:0] w_dest_salto;
    logic [WIDTH-1:0] w_dest_jump;
    logic [WIDTH-1:0] w_pc_sig;
    logic [1:0]       w_fuente;

    eval_cond u_eval_cond (
        .i_tipo_cond (i_tipo_cond),
        .i_zero      (i_zero),
        .i_negativo  (i_negativo),
        .o_cond      (w_cond)
    );

    assign w_tomado     = i_salto_cond & w_cond;
    assign w_pc_mas4    = r_pc + WIDTH'(32'd4);
    assign w_dest_salto = w_pc_mas4 + (i_inm_ext << 2);
    assign w_desal_req  = i_salto_reg && (i_reg_dest[1:0] != 2'b00);
    // An exception cuts through a stall; anything else waits.
    assign w_retenido   = i_stall && !i_excepcion;

    // Jump keeps the 256 MB region of the delay-slot address.
    if (WIDTH > 28) begin : g_jump_region
        assign w_dest_jump = {w_pc_mas4[WIDTH-1:28], i_dest_j, 2'b00};
    end else begin : g_jump_flat
        assign w_dest_jump = {i_dest_j, 2'b00};
    end

    // Fixed-priority source selection; only meaningful while executing.
    always_comb begin
        w_fuente = FPC_SEQ;
        w_pc_sig = w_pc_mas4;
        if (i_excepcion || w_desal_req) begin
            w_fuente = FPC_VECTOR;
            w_pc_sig = EXC_PC;
        end else if (i_salto_reg) begin
            w_fuente = FPC_JUMP;
            w_pc_sig = i_reg_dest;
        end else if (i_salto_incond) begin
            w_fuente = FPC_JUMP;
            w_pc_sig = w_dest_jump;
        end else if (w_tomado) begin
            w_fuente = FPC_SALTO;
            w_pc_sig = w_dest_salto;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_estado <= ARRANQUE;
            r_pc     <= RST_PC;
            r_flush  <= 1'b0;
            r_desal  <= 1'b0;
            r_valido <= 1'b0;
            r_cuenta <= '0;
        end else begin
            unique case (r_estado)
                ARRANQUE: begin
                    // Boot cycle: PC held at the reset vector, requests ignored.
                    r_estado <= EJECUTA;
                    r_valido <= 1'b1;
                    r_flush  <= 1'b0;
                    r_desal  <= 1'b0;
                end
                VECTOR: begin
                    // Leaves unconditionally, even under stall.
                    r_estado <= EJECUTA;
                    r_pc     <= w_pc_mas4;
                    r_valido <= 1'b1;
                    r_flush  <= 1'b0;
                    r_desal  <= 1'b0;
                end
                EJECUTA: begin
                    if (!w_retenido) begin
                        r_pc    <= w_pc_sig;
                        r_desal <= w_desal_req && !i_excepcion;
                        case (w_fuente)
                            FPC_VECTOR: begin
                                r_estado <= VECTOR;
                                r_valido <= 1'b0;
                                r_flush  <= 1'b1;
                            end
                            FPC_SEQ: begin
                                r_flush <= 1'b0;
                            end
                            default: begin
                                r_flush  <= 1'b1;
                                r_cuenta <= r_cuenta + 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    r_estado <= ARRANQUE;
                    r_valido <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_mas4       = w_pc_mas4;
    assign o_fuente_pc     = (r_estado == EJECUTA && !w_retenido) ? w_fuente : FPC_SEQ;
    assign o_flush         = r_flush;
    assign o_desalineado   = r_desal;
    assign o_valido        = r_valido;
    assign o_cuenta_saltos = r_cuenta;

endmodule

// File: tb/tb_fuente_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_fuente_pc_seq
// Directed steps followed by randomized traffic, every cycle compared against
// a behavioural model of the next-PC rules.
// -----------------------------------------------------------------------------
module tb_fuente_pc_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] EXC   = 32'h8000_0180;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              salto_cond = 1'b0;
    logic [2:0]        tipo_cond = 3'd0;
    logic              zero = 1'b0;
    logic              negativo = 1'b0;
    logic              salto_incond = 1'b0;
    logic              salto_reg = 1'b0;
    logic [WIDTH-1:0]  inm_ext = '0;
    logic [25:0]       dest_j = '0;
    logic [WIDTH-1:0]  reg_dest = '0;
    logic              excepcion = 1'b0;

    logic [WIDTH-1:0]  o_pc;
    logic [WIDTH-1:0]  o_pc_mas4;
    logic [1:0]        o_fuente_pc;
    logic              o_flush;
    logic              o_desalineado;
    logic              o_valido;
    logic [CNT_W-1:0]  o_cuenta_saltos;

    fuente_pc_seq #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (EXC),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_salto_cond    (salto_cond),
        .i_tipo_cond     (tipo_cond),
        .i_zero          (zero),
        .i_negativo      (negativo),
        .i_salto_incond  (salto_incond),
        .i_salto_reg     (salto_reg),
        .i_inm_ext       (inm_ext),
        .i_dest_j        (dest_j),
        .i_reg_dest      (reg_dest),
        .i_excepcion     (excepcion),
        .o_pc            (o_pc),
        .o_pc_mas4       (o_pc_mas4),
        .o_fuente_pc     (o_fuente_pc),
        .o_flush         (o_flush),
        .o_desalineado   (o_desalineado),
        .o_valido        (o_valido),
        .o_cuenta_saltos (o_cuenta_saltos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_vec;
    bit          m_flush;
    bit          m_desal;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input int t, input bit z, input bit n);
        case (t)
            0:       return z;
            1:       return !z;
            2:       return n || z;
            3:       return !n && !z;
            4:       return n;
            5:       return !n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_boot  = 1'b1;
        m_vec   = 1'b0;
        m_flush = 1'b0;
        m_desal = 1'b0;
        m_cnt   = 0;
    endtask

    // Winner and target for the current inputs, assuming normal execution.
    task automatic model_predict(output int src, output logic [31:0] nxt);
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (excepcion || (salto_reg && (reg_dest % 4 != 0))) begin
            src = 3;
            nxt = EXC;
        end else if (salto_reg) begin
            src = 2;
            nxt = reg_dest;
        end else if (salto_incond) begin
            src = 2;
            nxt = (seq & 32'hF000_0000) | (32'(dest_j) * 32'd4);
        end else if (salto_cond && ref_taken(int'(tipo_cond), zero, negativo)) begin
            src = 1;
            nxt = seq + inm_ext * 32'd4;
        end else begin
            src = 0;
            nxt = seq;
        end
    endtask

    task automatic model_step();
        int          src;
        logic [31:0] nxt;
        model_predict(src, nxt);
        if (m_boot) begin
            m_boot  = 1'b0;
            m_flush = 1'b0;
            m_desal = 1'b0;
        end else if (m_vec) begin
            m_vec   = 1'b0;
            m_pc    = m_pc + 32'd4;
            m_flush = 1'b0;
            m_desal = 1'b0;
        end else if (!(stall && !excepcion)) begin
            m_desal = (src == 3) && !excepcion;
            m_flush = (src != 0);
            m_vec   = (src == 3);
            if (src == 1 || src == 2) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_pc = nxt;
        end
    endtask

    // One clock: combinational checks before the edge, registered after.
    task automatic tick();
        int          src;
        logic [31:0] nxt;
        #1;
        chk("pc_mas4", o_pc_mas4, m_pc + 32'd4);
        if (m_boot || m_vec) begin
            chk("fuente_pc_quiet", o_fuente_pc, 0);
        end else if (!(stall && !excepcion)) begin
            model_predict(src, nxt);
            chk("fuente_pc", o_fuente_pc, src);
        end
        model_step();
        @(posedge clk);
        #1;
        chk("pc", o_pc, m_pc);
        chk("flush", o_flush, m_flush);
        chk("valido", o_valido, !m_boot && !m_vec);
        chk("desalineado", o_desalineado, m_desal);
        chk("cuenta", o_cuenta_saltos, m_cnt);
    endtask

    task automatic idle();
        stall        = 1'b0;
        salto_cond   = 1'b0;
        tipo_cond    = 3'd0;
        zero         = 1'b0;
        negativo     = 1'b0;
        salto_incond = 1'b0;
        salto_reg    = 1'b0;
        inm_ext      = '0;
        dest_j       = '0;
        reg_dest     = '0;
        excepcion    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] p0;
        int unsigned c0;
        logic [15:0] r16;

        // Reset and release
        idle();
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_valido", o_valido, 0);
        chk("rst_flush", o_flush, 0);
        chk("rst_cuenta", o_cuenta_saltos, 0);
        chk("rst_fuente", o_fuente_pc, 0);
        rst_n = 1'b1;
        #1;
        chk("boot_valido", o_valido, 0);
        tick();
        chk("boot_pc_held", o_pc, 32'h0);
        tick();
        chk("seq_pc4", o_pc, 32'h4);
        tick();
        chk("seq_pc8", o_pc, 32'h8);
        chk("seq_flush", o_flush, 0);

        // JR to 0x100, then BEQ backward by one word
        salto_reg = 1'b1;
        reg_dest  = 32'h100;
        tick();
        chk("jr_pc", o_pc, 32'h100);
        idle();
        salto_cond = 1'b1;
        tipo_cond  = 3'd0;
        zero       = 1'b1;
        inm_ext    = 32'hFFFF_FFFF;
        tick();
        chk("beq_taken_pc", o_pc, 32'h100);
        chk("beq_taken_flush", o_flush, 1);
        zero = 1'b0;
        tick();
        chk("beq_not_pc", o_pc, 32'h104);
        chk("beq_not_flush", o_flush, 0);

        // Condition sweep
        for (int t = 0; t < 8; t++) begin
            for (int zn = 0; zn < 4; zn++) begin
                idle();
                salto_cond = 1'b1;
                tipo_cond  = 3'(t);
                zero       = zn[0];
                negativo   = zn[1];
                inm_ext    = 32'h10;
                p0         = m_pc;
                tick();
                chk("cond_sweep", o_pc,
                    p0 + 32'd4 + (ref_taken(t, zn[0], zn[1]) ? 32'h40 : 32'h0));
            end
        end

        // Jump beats a simultaneous taken branch
        idle();
        salto_reg = 1'b1;
        reg_dest  = 32'h4000_0000;
        tick();
        idle();
        salto_incond = 1'b1;
        dest_j       = 26'h3FF_FFFF;
        salto_cond   = 1'b1;
        zero         = 1'b1;
        c0           = m_cnt;
        #1;
        chk("jump_fuente", o_fuente_pc, 2);
        tick();
        chk("jump_pc", o_pc, 32'h4FFF_FFFC);
        chk("jump_cnt", o_cuenta_saltos, (c0 + 1) % (1 << CNT_W));

        // Misaligned JR
        idle();
        salto_reg = 1'b1;
        reg_dest  = 32'h1002;
        tick();
        chk("desal_pulse", o_desalineado, 1);
        chk("desal_pc", o_pc, 32'h8000_0180);
        chk("desal_flush", o_flush, 1);
        chk("desal_valido", o_valido, 0);
        idle();
        tick();
        chk("post_vec_pc", o_pc, 32'h8000_0184);
        chk("post_vec_valido", o_valido, 1);
        chk("post_vec_desal", o_desalineado, 0);

        // Stall with a taken branch pending, then exception through the stall
        stall      = 1'b1;
        salto_cond = 1'b1;
        zero       = 1'b1;
        inm_ext    = 32'h20;
        p0         = m_pc;
        c0         = m_cnt;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", o_pc, p0);
            chk("stall_cnt", o_cuenta_saltos, c0);
        end
        excepcion = 1'b1;
        tick();
        chk("exc_stall_pc", o_pc, EXC);
        idle();
        tick();

        // Async reset mid-cycle with a flush pending
        salto_incond = 1'b1;
        dest_j       = 26'h40;
        tick();
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_pc", o_pc, 32'h0);
        chk("async_flush", o_flush, 0);
        chk("async_valido", o_valido, 0);
        chk("async_cnt", o_cuenta_saltos, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Boot cycle ignores stall and exception
        stall     = 1'b1;
        excepcion = 1'b1;
        tick();
        chk("boot_ignore_pc", o_pc, 32'h0);
        idle();
        tick();
        chk("boot_then_seq", o_pc, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall        = ($urandom_range(0, 4) == 0);
            excepcion    = ($urandom_range(0, 19) == 0);
            salto_reg    = ($urandom_range(0, 7) == 0);
            reg_dest     = $urandom;
            if ($urandom_range(0, 1) == 1) reg_dest[1:0] = 2'b00;
            salto_incond = ($urandom_range(0, 7) == 0);
            salto_cond   = ($urandom_range(0, 1) == 1);
            tipo_cond    = 3'($urandom_range(0, 7));
            zero         = ($urandom_range(0, 1) == 1);
            negativo     = ($urandom_range(0, 1) == 1);
            r16          = 16'($urandom);
            inm_ext      = {{16{r16[15]}}, r16};
            dest_j       = 26'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fuente_pc_seq.md
Name: fuente_pc_seq

Overview:
Registered next-PC generator for the MIPS32 core. It succeeds the single-cycle combinational branch-select gate.
- Owns the PC register and evaluates six conditional-branch types.
- Handles J/JAL, JR/JALR, stall, and an exception redirect with a one-cycle flush.
- Counts taken control transfers for performance monitoring.
- Sits between the control unit/ALU flags and the instruction-memory address port.

Parameters:
WIDTH, 32, PC/address width; legal range 28..64.
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset; zero-extended or truncated to WIDTH.
EXC_VECTOR, 32'h8000_0180, exception/misalignment target; zero-extended or truncated to WIDTH.
CNT_W, 16, width of the taken-transfer counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold PC, state and counter this cycle.
salto_cond  in  1  conditional branch instruction in decode.
tipo_cond  in  3  condition code (see package).
zero  in  1  ALU zero flag.
negativo  in  1  ALU sign flag.
salto_incond  in  1  J/JAL.
salto_reg  in  1  JR/JALR.
inm_ext  in  WIDTH  sign-extended 16-bit immediate.
dest_j  in  26  jump index field.
reg_dest  in  WIDTH  register target for JR.
excepcion  in  1  external exception request.
pc  out  WIDTH  current PC (registered).
pc_mas4  out  WIDTH  pc+4, combinational from pc.
fuente_pc  out  2  selected source: 0 seq, 1 branch, 2 jump/jr, 3 vector.
flush  out  1  registered; kill the instruction fetched in the previous cycle.
desalineado  out  1  registered; JR target had nonzero bits [1:0].
valido  out  1  fetch address valid.
cuenta_saltos  out  CNT_W  number of taken transfers.

Behaviour:
Reset (async, rst_n=0):
- pc=RESET_VECTOR, state=ARRANQUE.
- flush=0, desalineado=0, valido=0, cuenta_saltos=0.
- fuente_pc=0 while in reset.

States:
- ARRANQUE: one cycle after reset release. valido=0, pc held at RESET_VECTOR. Next state EJECUTA unconditionally; stall and excepcion are ignored here.
- EJECUTA: normal operation. valido=1.
- VECTOR: entered on exception or misalignment. pc←EXC_VECTOR, flush=1, valido=0 for one cycle. Next state EJECUTA, even if stall=1.

Condition taken (combinational, tipo_cond):
- 0 BEQ: zero.
- 1 BNE: !zero.
- 2 BLEZ: negativo|zero.
- 3 BGTZ: !negativo&!zero.
- 4 BLTZ: negativo.
- 5 BGEZ: !negativo.
- 6, 7: never taken.
- tomado = salto_cond & cond.

Targets (all arithmetic modulo 2^WIDTH):
- Branch: pc_mas4 + (inm_ext<<2).
- Jump: {pc_mas4[WIDTH-1:28], dest_j, 2'b00}.
- JR: reg_dest.

Priority in EJECUTA, highest first:
1. excepcion.
2. salto_reg with reg_dest[1:0]≠0 (misaligned): goes to VECTOR and pulses desalineado=1 for one cycle.
3. salto_reg, aligned.
4. salto_incond.
5. tomado.
6. sequential.

Simultaneous requests:
- Lower-priority requests in the same cycle are discarded.
- fuente_pc reflects only the winning source.

Update rules in EJECUTA:
- If stall=1 and excepcion=0: pc, state, flush and counter all hold.
- excepcion overrides stall.
- Any non-sequential, non-vector winner: flush=1 next cycle and cuenta_saltos increments. The counter wraps at 2^CNT_W−1→0.
- Sequential winner: flush=0.

Latency: the selected target appears on pc one clock after the deciding cycle.

Reset asserted mid-operation: all registers go immediately to their reset values. Any pending flush is dropped.

Decomposition:
- Package fuente_pc_pkg holds:
  - the tipo_cond localparams (COND_BEQ..COND_BGEZ);
  - the fuente_pc encodings (FPC_SEQ, FPC_SALTO, FPC_JUMP, FPC_VECTOR);
  - the state enum (ARRANQUE, EJECUTA, VECTOR).
- One sub-module, eval_cond, holds the purely combinational condition evaluator (tipo_cond, zero, negativo → cond).

Test Plan:
- Reset then release: pc=0 and valido=0 for one cycle. Then pc=0,4,8 on successive clocks with fuente_pc=0 and flush=0.
- At pc=0x100, BEQ with zero=1 and inm_ext=0xFFFFFFFF: next pc=0x100 and flush=1 next cycle. The same branch with zero=0 gives next pc=0x104.
- Sweep tipo_cond 0..7 against all four {zero,negativo} combinations. tomado must match the condition table exactly, and codes 6 and 7 are never taken.
- At pc=0x4000_0000, salto_incond=1 with dest_j=0x3FFFFFF and tomado=1 at the same time: pc=0x4FFF_FFFC, fuente_pc=2, cuenta_saltos+1.
- salto_reg=1 with reg_dest=0x1002: desalineado=1, pc=0x8000_0180, flush=1, valido=0 for one cycle, then EJECUTA at 0x8000_0184.
- stall=1 for 3 cycles with a taken branch pending: pc and counter are unchanged. excepcion asserted during the stall redirects pc to EXC_VECTOR regardless. Asserting rst_n=0 asynchronously mid-cycle forces pc=0 immediately.
